spike_filter_serializer: RTL

- Sits directly downstream of SpikeFilterArray; consumes its output channel (filt_idx, filt_state).
- Buffers filter records in a small FIFO and splits each record into fixed-width output words with a route code and sequence index.
- Drives the upstream-to-host word stream.
- Lets the filter array retire records at full rate while the host link stalls.

---
 rtl/spike_filter_serializer_if.sv | 26 ++
 rtl/spike_filter_serializer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/spike_filter_serializer_if.sv
// Record-in / word-out handshake bundle for spike_filter_serializer.
// master: the environment (drives records, accepts words).
// slave:  the serializer.
interface spike_filter_serializer_if #(
  parameter int Nfilts = 10,
  parameter int Nstate = 27,
  parameter int Nword  = 24
);
  logic              in_v;
  logic [Nfilts-1:0] in_filt_idx;
  logic [Nstate-1:0] in_filt_state;
  logic              in_a;
  logic              out_v;
  logic [Nword-1:0]  out_d;
  logic              out_a;

  modport master (
    output in_v, in_filt_idx, in_filt_state, out_a,
    input  in_a, out_v, out_d
  );

  modport slave (
    input  in_v, in_filt_idx, in_filt_state, out_a,
    output in_a, out_v, out_d
  );
endinterface

// File: rtl/spike_filter_serializer.sv
// spike_filter_serializer: buffers {filt_idx, filt_state} records from the
// filter array in a small FIFO and emits each one as K fixed-width words
// {Code, first, last, chunk}, lowest chunk first.
// Optional build macro SPIKE_FILTER_SERIALIZER_ZERO_SUPPRESS_EN: records with
// filt_state == 0 are accepted but dropped, and counted on suppressed_ct.
module spike_filter_serializer #(
  parameter int               Nfilts = 10,
  parameter int               Nstate = 27,
  parameter int               Nword  = 24,
  parameter int               Ncode  = 4,
  parameter logic [Ncode-1:0] Code   = 4'd9,
  parameter int               Depth  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  spike_filter_serializer_if.slave bus,
  output logic [$clog2(Depth):0]   fifo_count,
  output logic                     overflow_err
`ifdef SPIKE_FILTER_SERIALIZER_ZERO_SUPPRESS_EN
  ,
  output logic [15:0]              suppressed_ct
`endif
);

  localparam int NCHUNK = Nword - Ncode - 2;
  localparam int NREC   = Nfilts + Nstate;
  localparam int K      = (NREC + NCHUNK - 1) / NCHUNK;
  localparam int PW     = K * NCHUNK;
  localparam int AW     = $clog2(Depth);
  localparam int CW     = AW + 1;
  localparam int CTR_W  = (K > 1) ? $clog2(K) : 1;

  localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(K - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(Depth);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [CTR_W-1:0]  word_ctr, word_ctr_nxt;
  logic [NREC-1:0]   mem [Depth];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic [9:0]        stall_ctr;
  logic              accept, suppress, push, pop;

  // Build one output word from a record and a chunk index; the record is
  // zero-extended to K*NCHUNK bits before slicing.
  function automatic logic [Nword-1:0] format_word(input logic [NREC-1:0]  rec,
                                                   input logic [CTR_W-1:0] ctr);
    logic [PW-1:0] p;
    p = '0;
    p[NREC-1:0] = rec;
    return {Code, (ctr == '0), (ctr == LAST_CTR), p[int'(ctr)*NCHUNK +: NCHUNK]};
  endfunction

  // Input side: accept whenever the registered count shows room.
  assign bus.in_a = (fifo_count < DEPTH_C);
  assign accept   = bus.in_v && bus.in_a;
`ifdef SPIKE_FILTER_SERIALIZER_ZERO_SUPPRESS_EN
  assign suppress = (bus.in_filt_state == '0);
`else
  assign suppress = 1'b0;
`endif
  assign push = accept && !suppress;
  assign pop  = (state == SEND) && bus.out_a && (word_ctr == LAST_CTR);

  // Output word is a pure function of FIFO head and chunk index, so it holds
  // steady through a stall; forced to zero outside SEND.
  always_comb begin
    bus.out_v = (state == SEND);
    bus.out_d = '0;
    if (state == SEND) bus.out_d = format_word(mem[rd_ptr], word_ctr);
  end

  // Occupancy after this edge; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop)      count_nxt = fifo_count + 1'b1;
    else if (!push && pop) count_nxt = fifo_count - 1'b1;
  end

  // Record storage; data path carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_filt_idx, bus.in_filt_state};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_nxt;
    end
  end

  // Serializer FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      word_ctr <= '0;
    end else begin
      state    <= state_nxt;
      word_ctr <= word_ctr_nxt;
    end
  end

  // Serializer FSM next state: IDLE waits on the registered count; SEND steps
  // through chunks and chains straight into the next record when one remains.
  always_comb begin
    state_nxt    = state;
    word_ctr_nxt = word_ctr;
    if (state == IDLE) begin
      if (fifo_count != '0) begin
        state_nxt    = SEND;
        word_ctr_nxt = '0;
      end
    end else if (bus.out_a) begin
      if (word_ctr == LAST_CTR) begin
        word_ctr_nxt = '0;
        if (count_nxt == '0) state_nxt = IDLE;
      end else begin
        word_ctr_nxt = word_ctr + 1'b1;
      end
    end
  end

  // Stall watchdog: counts cycles a record waits on a full FIFO; the sticky
  // flag is purely diagnostic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_ctr    <= '0;
      overflow_err <= 1'b0;
    end else if (accept) begin
      stall_ctr <= '0;
    end else if (bus.in_v) begin
      stall_ctr <= stall_ctr + 1'b1;
      if (stall_ctr == 10'h3FF) overflow_err <= 1'b1;
    end
  end

`ifdef SPIKE_FILTER_SERIALIZER_ZERO_SUPPRESS_EN
  // Wrapping tally of accepted-but-dropped zero-state records.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  suppressed_ct <= '0;
    else if (accept && suppress) suppressed_ct <= suppressed_ct + 1'b1;
  end
`endif

endmodule
